// File: rtl/wb_psram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_psram_ctrl_pkg
// Purpose : Shared definitions for the Wishbone-to-CellularRAM controller.
//           - FSM state encoding
//           - Grouped device strobe pins and their inactive values
//           - Constant async-mode pin levels
//           - Helper that builds the strobe set for one device access
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package wb_psram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACC_HI = 3'd1,
        ST_GAP    = 3'd2,
        ST_ACC_LO = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    // Device-facing strobes kept together so a phase can load them in one go.
    typedef struct packed {
        logic       ce_n;
        logic       oe_n;
        logic       we_n;
        logic [1:0] be_n;
        logic       dat_oe;
    } pins_t;

    localparam pins_t PINS_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                    be_n: 2'b11, dat_oe: 1'b0};

    // Asynchronous mode: no device clock, address valid strobe tied active,
    // config register access disabled, shared flash kept off the bus.
    localparam logic SRAM_CLK_VAL   = 1'b0;
    localparam logic SRAM_ADV_N_VAL = 1'b0;
    localparam logic SRAM_CRE_VAL   = 1'b0;
    localparam logic FLASH_CE_N_VAL = 1'b1;

    // Strobe set for the first cycle of a half-word access. A write keeps
    // we_n low from the first cycle; the FSM raises it for the hold cycle.
    function automatic pins_t phase_pins(input logic we, input logic [1:0] sel_half);
        pins_t p;
        p      = PINS_IDLE;
        p.ce_n = 1'b0;
        if (we) begin
            p.we_n   = 1'b0;
            p.be_n   = ~sel_half;
            p.dat_oe = 1'b1;
        end else begin
            p.oe_n = 1'b0;
            p.be_n = 2'b00;
        end
        return p;
    endfunction

endpackage : wb_psram_ctrl_pkg
`default_nettype wire

// File: rtl/wb_psram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : wb_psram_if
// Purpose : Wishbone classic bus bundle between the interconnect (master)
//           and the PSRAM controller (slave).
// Ports   : wb_adr_i  byte address       wb_dat_i  write data
//           wb_dat_o  read data          wb_sel_i  byte selects ([3]=31:24)
//           wb_stb_i  strobe             wb_cyc_i  cycle
//           wb_we_i   write enable       wb_ack_o  acknowledge
// Revision: 1.0 - initial release
// ============================================================================
interface wb_psram_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_ack_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface : wb_psram_if
`default_nettype wire

// File: rtl/wb_psram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : wb_psram_ctrl
// Purpose : Wishbone classic slave driving a Micron CellularRAM in
//           asynchronous mode. A 32-bit access is split into a high then a
//           low 16-bit device access, each LATENCY cycles long, separated by
//           one idle GAP cycle. Writes skip halves whose byte selects are 0.
// Ports   : clk, reset          clock, synchronous active-high reset
//           wb (slave modport)  Wishbone bus
//           sram_adr            half-word address {word address, hw}, hw=0 high
//           sram_dat_i/_o/_oe   device data in/out and tristate enable
//           sram_be_n           byte enables ([1] = upper byte)
//           sram_ce_n/oe_n/we_n device strobes, active-low
//           sram_clk/adv_n/cre, flash_ce_n  constant async-mode levels
// Revision: 1.0 - initial release
// ============================================================================
module wb_psram_ctrl
    import wb_psram_ctrl_pkg::*;
#(
    parameter int ADR_WIDTH = 22,
    parameter int LATENCY   = 4
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    wb_psram_if.slave                 wb,
    output logic [ADR_WIDTH:0]        sram_adr,
    input  wire logic [15:0]          sram_dat_i,
    output logic [15:0]               sram_dat_o,
    output logic                      sram_dat_oe,
    output logic [1:0]                sram_be_n,
    output logic                      sram_ce_n,
    output logic                      sram_oe_n,
    output logic                      sram_we_n,
    output logic                      sram_clk,
    output logic                      sram_adv_n,
    output logic                      sram_cre,
    output logic                      flash_ce_n
);

    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    if (LATENCY < 2) begin : g_latency_check
        $error("wb_psram_ctrl: LATENCY must be at least 2");
    end

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    pins_t                  pins;
    logic                   ack;
    logic [31:0]            dat_rd;
    logic [ADR_WIDTH:0]     adr_q;
    logic [15:0]            dat_wr_q;

    // Request fields held for the low half, which may start after the bus
    // inputs have moved on.
    logic [ADR_WIDTH-1:0]   lat_adr;
    logic                   lat_we;
    logic [1:0]             lat_sel_lo;
    logic [15:0]            lat_dat_lo;
    logic                   lat_need_lo;

    logic                   need_hi;
    logic                   need_lo;
    logic                   unused_adr_bits;

    // Reads always touch both halves; writes only halves with a byte selected.
    assign need_hi = !wb.wb_we_i || (wb.wb_sel_i[3:2] != 2'b00);
    assign need_lo = !wb.wb_we_i || (wb.wb_sel_i[1:0] != 2'b00);

    assign unused_adr_bits = ^{wb.wb_adr_i[31:ADR_WIDTH+2], wb.wb_adr_i[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pins        <= PINS_IDLE;
            ack         <= 1'b0;
            dat_rd      <= '0;
            adr_q       <= '0;
            dat_wr_q    <= '0;
            lat_adr     <= '0;
            lat_we      <= 1'b0;
            lat_sel_lo  <= '0;
            lat_dat_lo  <= '0;
            lat_need_lo <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // While ack is still visible the master has not yet had
                    // a chance to drop stb, so the request is not new.
                    if (!ack && wb.wb_cyc_i && wb.wb_stb_i) begin
                        lat_adr     <= wb.wb_adr_i[ADR_WIDTH+1:2];
                        lat_we      <= wb.wb_we_i;
                        lat_sel_lo  <= wb.wb_sel_i[1:0];
                        lat_dat_lo  <= wb.wb_dat_i[15:0];
                        lat_need_lo <= need_lo;
                        if (need_hi) begin
                            state    <= ST_ACC_HI;
                            cnt      <= CNT_W'(LATENCY - 1);
                            pins     <= phase_pins(wb.wb_we_i, wb.wb_sel_i[3:2]);
                            adr_q    <= {wb.wb_adr_i[ADR_WIDTH+1:2], 1'b0};
                            dat_wr_q <= wb.wb_dat_i[31:16];
                        end else if (need_lo) begin
                            state    <= ST_ACC_LO;
                            cnt      <= CNT_W'(LATENCY - 1);
                            pins     <= phase_pins(wb.wb_we_i, wb.wb_sel_i[1:0]);
                            adr_q    <= {wb.wb_adr_i[ADR_WIDTH+1:2], 1'b1};
                            dat_wr_q <= wb.wb_dat_i[15:0];
                        end else begin
                            state <= ST_ACK;
                        end
                    end
                end

                ST_ACC_HI, ST_ACC_LO: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                        // Last cycle of a write: release we_n, keep data
                        // driven so the device sees hold time.
                        if (cnt == CNT_W'(1) && lat_we) begin
                            pins.we_n <= 1'b1;
                        end
                    end else begin
                        if (!lat_we) begin
                            if (state == ST_ACC_HI) begin
                                dat_rd[31:16] <= sram_dat_i;
                            end else begin
                                dat_rd[15:0]  <= sram_dat_i;
                            end
                        end
                        pins <= PINS_IDLE;
                        // A dropped cycle is only honoured once the device
                        // access has run to completion.
                        if (!wb.wb_cyc_i) begin
                            state <= ST_IDLE;
                        end else if (state == ST_ACC_HI && lat_need_lo) begin
                            state <= ST_GAP;
                        end else begin
                            state <= ST_ACK;
                        end
                    end
                end

                ST_GAP: begin
                    state    <= ST_ACC_LO;
                    cnt      <= CNT_W'(LATENCY - 1);
                    pins     <= phase_pins(lat_we, lat_sel_lo);
                    adr_q    <= {lat_adr, 1'b1};
                    dat_wr_q <= lat_dat_lo;
                end

                ST_ACK: begin
                    ack   <= 1'b1;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    pins  <= PINS_IDLE;
                end
            endcase
        end
    end

    assign wb.wb_ack_o = ack;
    assign wb.wb_dat_o = dat_rd;

    assign sram_adr    = adr_q;
    assign sram_dat_o  = dat_wr_q;
    assign sram_dat_oe = pins.dat_oe;
    assign sram_be_n   = pins.be_n;
    assign sram_ce_n   = pins.ce_n;
    assign sram_oe_n   = pins.oe_n;
    assign sram_we_n   = pins.we_n;

    assign sram_clk    = SRAM_CLK_VAL;
    assign sram_adv_n  = SRAM_ADV_N_VAL;
    assign sram_cre    = SRAM_CRE_VAL;
    assign flash_ce_n  = FLASH_CE_N_VAL;

endmodule : wb_psram_ctrl
`default_nettype wire

// File: tb/tb_wb_psram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_psram_ctrl
// Purpose : Self-checking bench for wb_psram_ctrl with a behavioural
//           CellularRAM model and queue-based expectations for device
//           phases and read data.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_psram_ctrl;

    localparam int ADR_WIDTH = 22;
    localparam int LAT       = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_psram_if wb();

    logic [ADR_WIDTH:0] sram_adr;
    logic [15:0]        sram_dat_i, sram_dat_o;
    logic               sram_dat_oe;
    logic [1:0]         sram_be_n;
    logic               sram_ce_n, sram_oe_n, sram_we_n;
    logic               sram_clk, sram_adv_n, sram_cre, flash_ce_n;

    wb_psram_ctrl #(.ADR_WIDTH(ADR_WIDTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb         (wb),
        .sram_adr   (sram_adr),
        .sram_dat_i (sram_dat_i),
        .sram_dat_o (sram_dat_o),
        .sram_dat_oe(sram_dat_oe),
        .sram_be_n  (sram_be_n),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_clk   (sram_clk),
        .sram_adv_n (sram_adv_n),
        .sram_cre   (sram_cre),
        .flash_ce_n (flash_ce_n)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- device model ----------------
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_be_n[1]) mem[sram_adr[7:0]][15:8] <= sram_dat_o[15:8];
            if (!sram_be_n[0]) mem[sram_adr[7:0]][7:0]  <= sram_dat_o[7:0];
        end
    end
    assign sram_dat_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_adr[7:0]] : 16'h0000;

    // ---------------- scoreboards ----------------
    typedef struct packed {
        logic [ADR_WIDTH:0] adr;
        logic [15:0]        dat;
        logic [1:0]         be_n;
    } wr_t;

    wr_t                wr_q[$];
    logic [ADR_WIDTH:0] rd_q[$];
    logic [31:0]        rdat_q[$];

    // ---------------- phase monitor ----------------
    int          phases = 0;
    bit          skip_shape = 1'b0;
    bit          in_ph = 1'b0;
    bit          is_wr;
    bit          dat_moved;
    int          ce_low, wlow;
    logic [15:0] held_dat;
    wr_t         e_wr;
    logic [ADR_WIDTH:0] e_rd;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            in_ph = 1'b0;
        end else if (sram_ce_n === 1'b0) begin
            if (!in_ph) begin
                in_ph     = 1'b1;
                phases++;
                ce_low    = 0;
                wlow      = 0;
                dat_moved = 1'b0;
                is_wr     = (sram_we_n === 1'b0);
                held_dat  = sram_dat_o;
                total++;
                if (is_wr) begin
                    if (wr_q.size() == 0) begin
                        bad++;
                        $display("FAIL wr_phase_unexpected adr=%h dat=%h", sram_adr, sram_dat_o);
                    end else begin
                        e_wr = wr_q.pop_front();
                        if ({sram_adr, sram_dat_o, sram_be_n, sram_dat_oe} !==
                            {e_wr.adr, e_wr.dat, e_wr.be_n, 1'b1}) begin
                            bad++;
                            $display("FAIL wr_phase got adr=%h dat=%h be_n=%b oe=%b want adr=%h dat=%h be_n=%b oe=1",
                                     sram_adr, sram_dat_o, sram_be_n, sram_dat_oe, e_wr.adr, e_wr.dat, e_wr.be_n);
                        end
                    end
                end else begin
                    if (rd_q.size() == 0) begin
                        bad++;
                        $display("FAIL rd_phase_unexpected adr=%h", sram_adr);
                    end else begin
                        e_rd = rd_q.pop_front();
                        if ({sram_adr, sram_oe_n, sram_be_n, sram_dat_oe} !== {e_rd, 1'b0, 2'b00, 1'b0}) begin
                            bad++;
                            $display("FAIL rd_phase got adr=%h oe_n=%b be_n=%b dat_oe=%b want adr=%h oe_n=0 be_n=00 dat_oe=0",
                                     sram_adr, sram_oe_n, sram_be_n, sram_dat_oe, e_rd);
                        end
                    end
                end
            end
            ce_low++;
            if (sram_we_n === 1'b0) wlow++;
            if (is_wr && (sram_dat_o !== held_dat || sram_dat_oe !== 1'b1)) dat_moved = 1'b1;
        end else if (in_ph) begin
            in_ph = 1'b0;
            if (!skip_shape) begin
                total++;
                if (ce_low != LAT || wlow != (is_wr ? LAT - 1 : 0) || dat_moved) begin
                    bad++;
                    $display("FAIL phase_shape got ce_low=%0d we_low=%0d dat_moved=%0d want ce_low=%0d we_low=%0d dat_moved=0",
                             ce_low, wlow, dat_moved, LAT, is_wr ? LAT - 1 : 0);
                end
            end
        end
    end

    // ---------------- bus helpers ----------------
    task automatic drive_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel);
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        wb.wb_we_i  = we;
        wb.wb_adr_i = adr;
        wb.wb_dat_i = dat;
        wb.wb_sel_i = sel;
    endtask

    task automatic drop_req();
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
    endtask

    // Returns the number of rising edges from the sampling edge to the edge
    // that raised ack (-1 on timeout), plus read data seen with ack.
    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output int edges, output logic [31:0] rdata);
        bit got;
        @(negedge clk);
        drive_req(we, adr, dat, sel);
        @(posedge clk);
        edges = 0;
        got   = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (wb.wb_ack_o === 1'b1) got = 1'b1;
            else begin
                @(posedge clk);
                edges++;
            end
        end
        rdata = wb.wb_dat_o;
        drop_req();
        if (!got) edges = -1;
        @(negedge clk);
        total++;
        if (wb.wb_ack_o !== 1'b0) begin
            bad++;
            $display("FAIL ack_width got ack=%b one cycle later want 0", wb.wb_ack_o);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (wb.wb_ack_o !== 1'b0 || wb.wb_dat_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_wb got ack=%b dat=%h want ack=0 dat=0", wb.wb_ack_o, wb.wb_dat_o);
        end
        total++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dat_oe} !== 6'b111110) begin
            bad++;
            $display("FAIL reset_strobes got %b want 111110",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dat_oe});
        end
        total++;
        if (sram_adr !== '0 || sram_dat_o !== 16'h0) begin
            bad++;
            $display("FAIL reset_adr_dat got adr=%h dat=%h want 0 0", sram_adr, sram_dat_o);
        end
        total++;
        if ({sram_clk, sram_adv_n, sram_cre, flash_ce_n} !== 4'b0001) begin
            bad++;
            $display("FAIL const_pins got %b want 0001", {sram_clk, sram_adv_n, sram_cre, flash_ce_n});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_write();
        int edges; logic [31:0] rd;
        wr_q.push_back('{adr: 23'h000080, dat: 16'hDEAD, be_n: 2'b00});
        wr_q.push_back('{adr: 23'h000081, dat: 16'hBEEF, be_n: 2'b00});
        wb_access(1'b1, 32'h4000_0100, 32'hDEAD_BEEF, 4'b1111, edges, rd);
        total++;
        if (edges != 10) begin
            bad++;
            $display("FAIL full_write_ack_edge got %0d want 10", edges);
        end
    endtask

    task automatic test_read(input string name, input logic [31:0] adr, input logic [31:0] expd);
        int edges; logic [31:0] rd; logic [31:0] want;
        rd_q.push_back({adr[ADR_WIDTH+1:2], 1'b0});
        rd_q.push_back({adr[ADR_WIDTH+1:2], 1'b1});
        rdat_q.push_back(expd);
        wb_access(1'b0, adr, 32'h0, 4'b1111, edges, rd);
        total++;
        if (edges != 10) begin
            bad++;
            $display("FAIL %s_ack_edge got %0d want 10", name, edges);
        end
        want = rdat_q.pop_front();
        total++;
        if (rd !== want) begin
            bad++;
            $display("FAIL %s_data got %h want %h", name, rd, want);
        end
    endtask

    task automatic test_partial_write();
        int edges; logic [31:0] rd;
        wr_q.push_back('{adr: 23'h000081, dat: 16'h5500, be_n: 2'b01});
        wb_access(1'b1, 32'h4000_0100, 32'h0000_5500, 4'b0010, edges, rd);
        total++;
        if (edges != 5) begin
            bad++;
            $display("FAIL partial_write_ack_edge got %0d want 5", edges);
        end
        test_read("partial_readback", 32'h4000_0100, 32'hDEAD_55EF);
    endtask

    task automatic test_sel_zero(input string name);
        int edges; int p0; logic [31:0] rd;
        p0 = phases;
        wb_access(1'b1, 32'h4000_0200, 32'hFFFF_FFFF, 4'b0000, edges, rd);
        total++;
        if (edges != 1) begin
            bad++;
            $display("FAIL %s_ack_edge got %0d want 1", name, edges);
        end
        total++;
        if (phases != p0) begin
            bad++;
            $display("FAIL %s_no_phase got %0d phases want 0", name, phases - p0);
        end
    endtask

    task automatic test_reset_mid();
        bit acked;
        skip_shape = 1'b1;
        wr_q.push_back('{adr: 23'h000080, dat: 16'hDEAD, be_n: 2'b00});
        @(negedge clk);
        drive_req(1'b1, 32'h4000_0100, 32'hDEAD_0000, 4'b1100);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dat_oe, wb.wb_ack_o} !== 5'b11100) begin
            bad++;
            $display("FAIL reset_mid_strobes got ce_n/oe_n/we_n/dat_oe/ack=%b want 11100",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_dat_oe, wb.wb_ack_o});
        end
        reset = 1'b0;
        drop_req();
        acked = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (wb.wb_ack_o !== 1'b0) acked = 1'b1;
        end
        total++;
        if (acked) begin
            bad++;
            $display("FAIL reset_mid_no_ack got ack=1 want 0");
        end
        skip_shape = 1'b0;
        test_read("after_reset_read", 32'h4000_0100, 32'hDEAD_55EF);
    endtask

    task automatic test_abort_read();
        bit acked; int p0;
        p0 = phases;
        rd_q.push_back(23'h000080);
        @(negedge clk);
        drive_req(1'b0, 32'h4000_0100, 32'h0, 4'b1111);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        drop_req();
        acked = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (wb.wb_ack_o !== 1'b0) acked = 1'b1;
        end
        total++;
        if (acked) begin
            bad++;
            $display("FAIL abort_no_ack got ack=1 want 0");
        end
        total++;
        if (phases != p0 + 1) begin
            bad++;
            $display("FAIL abort_phase_count got %0d want 1", phases - p0);
        end
        test_sel_zero("abort_then_idle");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        reset       = 1'b1;
        wb.wb_adr_i = '0;
        wb.wb_dat_i = '0;
        wb.wb_sel_i = '0;
        drop_req();

        test_reset();
        test_full_write();
        test_read("full_read", 32'h4000_0100, 32'hDEAD_BEEF);
        test_partial_write();
        test_sel_zero("sel_zero");
        test_reset_mid();
        test_abort_read();

        repeat (4) @(negedge clk);
        total++;
        if (wr_q.size() != 0 || rd_q.size() != 0 || rdat_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expect got wr=%0d rd=%0d dat=%0d want 0 0 0",
                     wr_q.size(), rd_q.size(), rdat_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wb_psram_ctrl
`default_nettype wire

// File: doc/wb_psram_ctrl.md
Name: wb_psram_ctrl

Overview:
- Wishbone classic slave that sequences the Nexys2 Micron CellularRAM (PSRAM) in asynchronous mode.
- Each 32-bit Wishbone access becomes up to two 16-bit device accesses: high half first (big-endian LM32), then low half.
- Sits on interconnect slave s0 (0x4xxxxxxx). It replaces the temporary BRAM test memory on that slot.
- The board top owns the tristate buffer for sram_dat.

Parameters:
- adr_width, 22, number of 32-bit word address bits taken from wb_adr_i[adr_width+1:2]; sram_adr is adr_width+1 bits wide.
- latency, 4, clock cycles per half-word device access; must be >= 2 (70 ns device at 50 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wb_adr_i  in  32  byte address
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, registered
- wb_sel_i  in  4  byte selects; [3] = bits 31:24
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_we_i  in  1  write enable
- wb_ack_o  out  1  single-cycle acknowledge
- sram_adr  out  adr_width+1  half-word address = {wb_adr_i[adr_width+1:2], hw}; hw=0 selects the high half
- sram_dat_i  in  16  device read data
- sram_dat_o  out  16  device write data
- sram_dat_oe  out  1  drive enable for the top-level tristate
- sram_be_n  out  2  byte enables; [1] = upper byte
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  device strobes, active-low
- sram_clk, sram_adv_n, sram_cre, flash_ce_n  out  1 each  constants 0, 0, 0, 1 (async mode, flash deselected)

Behaviour:
- All outputs except the constant pins are registered. Every state change occurs on a rising clk edge.
- Reset state: state IDLE, wb_ack_o=0, wb_dat_o=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=2'b11, sram_dat_oe=0, sram_adr=0, sram_dat_o=0.
- Reset mid-operation: next cycle all strobes are inactive and the FSM is in IDLE. No ack is issued for the aborted access.
- FSM states: IDLE, ACC_HI, GAP, ACC_LO, ACK.
- IDLE:
  - On cyc&stb, latch address, we, sel and data.
  - Select the first needed half:
    - Reads always need both halves.
    - Writes need the high half only if sel[3:2]!=0, and the low half only if sel[1:0]!=0.
  - Go to ACC_HI, ACC_LO, or ACK (write with sel=0000).
- ACC_x:
  - A down-counter is loaded with latency-1; the phase lasts exactly latency cycles.
  - sram_ce_n=0 throughout the phase.
  - Read phase: sram_oe_n=0, sram_be_n=00, sram_dat_oe=0. sram_dat_i is captured into the matching wb_dat_o half on the final cycle.
  - Write phase: sram_dat_oe=1 with data held for the whole phase. sram_we_n=0 for the first latency-1 cycles and 1 on the final cycle (data hold). sram_be_n = ~sel of that half.
- GAP: one cycle with ce_n, oe_n and we_n all high, entered only between ACC_HI and ACC_LO.
- ACK: wb_ack_o=1 for exactly one cycle, then IDLE. IDLE does not re-sample stb in that same cycle.
- Ack timing: with N = number of halves accessed, ack is high in the cycle starting N*latency + (N==2) + 1 edges after the edge that sampled the request.
  - latency=4: full read/write 10 edges, single-half write 5 edges, sel=0000 write 1 edge.
- Abort: if cyc_i is low at the end of any ACC phase, that phase completes for device timing and the FSM returns to IDLE with no ack.
- stb_i/cyc_i changes during an ACC phase never shorten the phase.
- Address arithmetic: no wrap checks; upper wb_adr_i bits above adr_width+1 are ignored.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, ACC_HI, GAP, ACC_LO, ACK)
  - the inactive pin values (strobes high, be_n 11)
  - the async-mode constant pin values
- Single module; no sub-module is warranted. The phase counter is inline.

Test Plan:
- Write 0xDEADBEEF to 0x40000100, sel=1111 -> device write adr 0x000080 data 0xDEAD be_n=00, GAP, then adr 0x000081 data 0xBEEF be_n=00; we_n low 3 cycles per phase; ack at edge 10.
- Read 0x40000100 after the above (bench device model returns written data) -> two oe_n phases at 0x80 and 0x81; wb_dat_o=0xDEADBEEF with ack at edge 10.
- Write sel=0010 data 0x00005500 to 0x40000100 -> only low phase, adr 0x81, be_n=01, data 0x5500; ack at edge 5. Read-back gives 0xDEAD55EF.
- Write sel=0000 -> no ce_n activity, ack at edge 1.
- Assert reset for one cycle during ACC_HI of a write -> next cycle ce_n=we_n=1, dat_oe=0, no ack; a following read of 0x40000100 completes normally in 10 edges.
- Drop cyc_i during ACC_HI of a read -> ACC_HI runs its full 4 cycles, no GAP/ACC_LO, no ack, FSM back in IDLE.
